// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: WIDTH-bit add/subtract built from a 2-bit slice that is
// stepped one digit (two bits) per clock, least-significant digit first.
// Optional feature macro: ADDSUB_OVF_EN. When it is defined, signed overflow
// is registered; otherwise the overflow output is tied low.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [1:0]       sum_dig;
    logic             c_mid;
    logic             c_out;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // 2-bit add/subtract slice on the current digit; b is inverted for subtract
    always_comb begin
        a_dig      = 2'(a_q >> {idx, 1'b0});
        b_dig      = 2'(b_q >> {idx, 1'b0}) ^ {2{mode_q}};
        sum_dig[0] = a_dig[0] ^ b_dig[0] ^ carry;
        c_mid      = (a_dig[0] & b_dig[0]) | (carry & (a_dig[0] ^ b_dig[0]));
        sum_dig[1] = a_dig[1] ^ b_dig[1] ^ c_mid;
        c_out      = (a_dig[1] & b_dig[1]) | (c_mid & (a_dig[1] ^ b_dig[1]));
    end

    // Sequencer: latch operands, step digits, hold inter-digit carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        carry  <= mode;
                        idx    <= '0;
                        result <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // result was cleared on start, so OR-ing each digit in is
                    // equivalent to writing the 2-bit field at idx
                    result <= result | (WIDTH'(sum_dig) << {idx, 1'b0});
                    carry  <= c_out;
                    if (idx == LAST_IDX) begin
                        cout  <= c_out;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into MSB xor carry out of MSB on the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && idx == LAST_IDX) begin
            ovf_q <= c_mid ^ c_out;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Sequential controller that performs a WIDTH-bit add or subtract by running operands through a 2-bit add/subtract slice, two bits per clock. It sits between the lab top level (switches/buttons or a host FSM) and the 2-bit adder datapath. It sequences the datapath by latching operands, stepping the digit index, and holding the inter-digit carry. Results, carry-out and signed overflow are presented with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; even, ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = add (a+b), 1 = subtract (a−b); latched with start
- a  in  WIDTH  operand A; latched with start
- b  in  WIDTH  operand B; latched with start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse, high while state is DONE
- result  out  WIDTH  a±b mod 2^WIDTH; registered
- cout  out  1  final carry out of MSB (subtract: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b, mode; carry ← mode; idx ← 0; result ← 0; go to RUN. IDLE, start=0: hold.
- RUN, each cycle, for digit idx (bits 2·idx+1 : 2·idx):
  - The slice adds a_digit + (b_digit XOR {mode,mode}) + carry.
  - Both b bits are inverted when mode=1.
  - The 2-bit sum is written into result[2·idx+1:2·idx], and carry ← slice carry-out.
  - When idx = WIDTH/2−1: cout ← slice carry-out, overflow ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), go to DONE. Otherwise idx ← idx+1.
- DONE: go to IDLE unconditionally. start is ignored in DONE.
- start is ignored in RUN and DONE; no queuing. Inputs a, b, mode may change freely after the start edge.
- result, cout and overflow hold their values until the next accepted start clears result.
- idx width is clog2(WIDTH/2), minimum 1. No wrap-around beyond WIDTH/2−1.

## Timing
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; internal carry, idx and operand registers cleared. Release is synchronous to the next clk edge.
- Outputs are Moore-style registered: busy = (state==RUN), done = (state==DONE).
- Let edge E0 sample start=1 in IDLE:
  - busy=1 from E0 to E(WIDTH/2).
  - Digits are computed at edges E1..E(WIDTH/2).
  - done=1 for exactly the cycle between E(WIDTH/2) and E(WIDTH/2+1); result, cout and overflow are final in that same cycle.
  - Earliest next accepted start is at edge E(WIDTH/2+1)+1, sampled in IDLE.
- Throughput: one operation per WIDTH/2+2 cycles. For WIDTH=8: latency 4 cycles to done, 6 cycles per operation.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial result is discarded (result=0), and done is never pulsed for the aborted operation.

## Configuration
- Macro ADDSUB_OVF_EN.
- Defined: overflow is computed and registered as described above.
- Undefined: overflow is tied to 0, and no logic is built to track the carry into the MSB. The port is still present.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=8 and the ADDSUB_OVF_EN build unless noted.
- Add, mode=0, a=0x5A, b=0x33 → done after 4 cycles; result=0x8D, cout=0, overflow=1. Without the macro, overflow=0.
- Subtract, mode=1, a=0x10, b=0x01 → result=0x0F, cout=1, overflow=0. Also a=0x00, b=0x01 → result=0xFF, cout=0, overflow=0.
- Signed boundary:
  - Subtract a=0x80, b=0x01 → result=0x7F, cout=1, overflow=1.
  - Add a=0xFF, b=0x01 → result=0x00, cout=1, overflow=0.
- start held high continuously, and operands changed during RUN → one operation per 6 cycles. Each result uses the operands latched at its accepting edge. busy and done never overlap.
- rst_n pulsed low during the second RUN cycle → all outputs 0 at once, no done pulse. A new start after release completes normally: a=0x01, b=0x01 add → 0x02.
